sub_int_seq: RTL and testbench
==============================

SUB_INT_SEQ -- requirements
Module: sub_int_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 8, bits processed per cycle; WIDTH mod DIGIT = 0, DIGIT >= 1.
REQ-003 SHALL have parameter IMPL_TYPE, default 0, passed unchanged to the per-digit subtractor slice; SHALL NOT alter cycle behaviour.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  operands presented.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port A  input  WIDTH  minuend.
REQ-009 SHALL have port B  input  WIDTH  subtrahend.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port Sub  output  WIDTH  A - B modulo 2^WIDTH.
REQ-013 SHALL have port Borrow  output  1  final borrow; 1 iff A < B unsigned.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; N = WIDTH/DIGIT.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, in_valid=1 at a rising edge SHALL capture A, B, clear borrow and digit counter, and move to BUSY.
REQ-017 Each BUSY cycle SHALL compute one DIGIT-bit slice, least significant first: slice = a_d - b_d - borrow; borrow_next = 1 iff a_d < b_d + borrow.
REQ-018 After the Nth BUSY cycle the FSM SHALL enter DONE; out_valid rises exactly N cycles after the accepting edge.
REQ-019 Sub and Borrow SHALL hold stable throughout DONE regardless of A, B, in_valid changes.
REQ-020 DONE with out_ready=1 at an edge SHALL return to IDLE; no operand accept in the same cycle (min. issue interval N+2 cycles with out_ready held high).
REQ-021 DONE with out_ready=0 SHALL stall indefinitely with outputs held.
REQ-022 DIGIT = WIDTH SHALL give N = 1 (single BUSY cycle); DIGIT = 1 SHALL give fully bit-serial operation.
REQ-023 A, B and in_valid SHALL be ignored outside IDLE.
REQ-024 Sub SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, in_ready=1, out_valid=0, Sub=0, Borrow=0, counter=0, internal operand registers=0.
REQ-026 rst asserted in BUSY or DONE SHALL abort the operation; the in-flight result SHALL never appear.
REQ-027 First accept after rst deasserts SHALL be possible at the first rising edge with rst=0.

Configuration
REQ-028 Macro SUB_INT_SEQ_OVF_EN: when defined, SHALL add port Ovf  output  1, valid with out_valid, = signed two's-complement overflow (sign(A) != sign(B) and sign(Sub) != sign(A)); reset value 0, held in DONE.
REQ-029 Without SUB_INT_SEQ_OVF_EN, port Ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=32, DIGIT=8, N=4 unless stated)
REQ-030 A=0x0000_0010, B=0x0000_0001, out_ready=1 -> out_valid 4 cycles after accept, Sub=0x0000_000F, Borrow=0, then in_ready=1 next cycle.
REQ-031 A=0x0000_0000, B=0x0000_0001 -> Sub=0xFFFF_FFFF, Borrow=1 (borrow ripples across all 4 digits); with OVF_EN, Ovf=0.
REQ-032 OVF_EN: A=0x8000_0000, B=0x0000_0001 -> Sub=0x7FFF_FFFF, Borrow=0, Ovf=1.
REQ-033 out_ready=0 for 10 cycles in DONE while A/B/in_valid toggle -> Sub, Borrow, out_valid unchanged, in_ready=0; result consumed on first out_ready=1 edge.
REQ-034 rst pulsed during 2nd BUSY cycle -> in_ready=1, out_valid=0, Sub=0 immediately; next operation A=5, B=3 -> Sub=2.
REQ-035 Sweep DIGIT in {1, 8, 32}, 1000 random operand pairs each -> Sub, Borrow match A-B reference; latency exactly WIDTH/DIGIT cycles.

Source files
------------

// File: rtl/sub_int_seq.sv
`timescale 1ns/1ps
// sub_int_seq: multi-cycle A - B subtractor, DIGIT bits per BUSY cycle, least significant digit first.
// Build option SUB_INT_SEQ_OVF_EN adds the Ovf output (signed two's-complement overflow).

module sub_int_seq_slice #(
    parameter int DIGIT     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             bin_i,
    output logic [DIGIT-1:0] diff_o,
    output logic             bout_o
);
    generate
        if (IMPL_TYPE == 1) begin : g_ripple
            logic [DIGIT:0] brw;
            always_comb begin
                diff_o = '0;
                brw    = '0;
                brw[0] = bin_i;
                for (int i = 0; i < DIGIT; i++) begin
                    diff_o[i] = a_i[i] ^ b_i[i] ^ brw[i];
                    brw[i+1]  = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & brw[i]);
                end
            end
            assign bout_o = brw[DIGIT];
        end else begin : g_behav
            // One extra bit: the extended result is negative exactly when a < b + bin.
            logic [DIGIT:0] ext;
            assign ext    = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT{1'b0}}, bin_i};
            assign diff_o = ext[DIGIT-1:0];
            assign bout_o = ext[DIGIT];
        end
    endgenerate
endmodule

module sub_int_seq #(
    parameter int WIDTH     = 32,
    parameter int DIGIT     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sub,
    output logic             Borrow
`ifdef SUB_INT_SEQ_OVF_EN
    ,
    output logic             Ovf
`endif
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // BUSY  | one digit per cycle, N cycles
    // DONE  | result held, out_valid=1 until out_ready
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sub_q, sub_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIGIT-1:0] diff;
    logic             bout;

    sub_int_seq_slice #(
        .DIGIT     (DIGIT),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_slice (
        .a_i    (a_q[DIGIT-1:0]),
        .b_i    (b_q[DIGIT-1:0]),
        .bin_i  (borrow_q),
        .diff_o (diff),
        .bout_o (bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Operands shift down so the slice always sees the current digit;
                // results enter from the top and land in place after N shifts.
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                sub_d    = (sub_q >> DIGIT) | (WIDTH'(diff) << (WIDTH - DIGIT));
                borrow_d = bout;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Sub       = sub_q;
    assign Borrow    = borrow_q;

`ifdef SUB_INT_SEQ_OVF_EN
    logic sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            ovf_q <= ovf_d;
        end
    end

    // Operand signs are kept aside because a_q/b_q are shifted away during BUSY.
    always_comb begin
        sa_d  = sa_q;
        sb_d  = sb_q;
        ovf_d = ovf_q;
        if (state_q == IDLE && in_valid) begin
            sa_d  = A[WIDTH-1];
            sb_d  = B[WIDTH-1];
            ovf_d = 1'b0;
        end
        if (state_q == BUSY && cnt_q == CNT_LAST) begin
            ovf_d = (sa_q ^ sb_q) & (diff[DIGIT-1] ^ sa_q);
        end
    end

    assign Ovf = ovf_q;
`endif
endmodule

// File: tb/tb_sub_int_seq.sv
`timescale 1ns/1ps
// Bench for sub_int_seq: directed vector table, multi-cycle corner sequences and a random
// sweep of three DIGIT variants against an arithmetic reference.

module tb_sub_int_seq;
    localparam int W = 32;

    logic         clk, rst, in_valid, out_ready;
    logic [W-1:0] A, B;

    logic         u8_in_ready, u8_out_valid, u8_borrow;
    logic [W-1:0] u8_sub;
    logic         u1_in_ready, u1_out_valid, u1_borrow;
    logic [W-1:0] u1_sub;
    logic         u32_in_ready, u32_out_valid, u32_borrow;
    logic [W-1:0] u32_sub;
`ifdef SUB_INT_SEQ_OVF_EN
    logic         u8_ovf, u1_ovf, u32_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sub_int_seq #(.WIDTH(W), .DIGIT(8), .IMPL_TYPE(0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u8_in_ready),
        .A(A), .B(B), .out_valid(u8_out_valid), .out_ready(out_ready),
        .Sub(u8_sub), .Borrow(u8_borrow)
`ifdef SUB_INT_SEQ_OVF_EN
        , .Ovf(u8_ovf)
`endif
    );

    sub_int_seq #(.WIDTH(W), .DIGIT(1), .IMPL_TYPE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u1_in_ready),
        .A(A), .B(B), .out_valid(u1_out_valid), .out_ready(out_ready),
        .Sub(u1_sub), .Borrow(u1_borrow)
`ifdef SUB_INT_SEQ_OVF_EN
        , .Ovf(u1_ovf)
`endif
    );

    sub_int_seq #(.WIDTH(W), .DIGIT(32), .IMPL_TYPE(0)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u32_in_ready),
        .A(A), .B(B), .out_valid(u32_out_valid), .out_ready(out_ready),
        .Sub(u32_sub), .Borrow(u32_borrow)
`ifdef SUB_INT_SEQ_OVF_EN
        , .Ovf(u32_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish before", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sub;
        logic         brw;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic dut8_ovf();
`ifdef SUB_INT_SEQ_OVF_EN
        return u8_ovf;
`else
        return 1'b0;
`endif
    endfunction

`ifdef SUB_INT_SEQ_OVF_EN
    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        return (d > 64'sd2147483647) || (d < -64'sd2147483648);
    endfunction
`endif

    // Issue one operation on the DIGIT=8 instance and wait (bounded) for its result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] s, output logic br, output logic ov, output int lat);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        lat = 999;
        s   = '0;
        br  = 1'b0;
        ov  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (u8_out_valid) begin
                lat = k;
                s   = u8_sub;
                br  = u8_borrow;
                ov  = dut8_ovf();
                break;
            end
        end
    endtask

    initial begin
        logic [W-1:0] s, a, b, exp_sub;
        logic         br, ov, exp_br;
        int           lat;

        vecs[0] = '{32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        vecs[6] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h8765_4321, 32'h8ACF_1357, 1'b1, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        A = 32'hDEAD_BEEF;
        B = 32'h1234_5678;
        #12;
        check("rst_in_ready", 64'(u8_in_ready), 64'(1'b1));
        check("rst_out_valid", 64'(u8_out_valid), 64'(1'b0));
        check("rst_sub", 64'(u8_sub), 64'(32'h0));
        check("rst_borrow", 64'(u8_borrow), 64'(1'b0));
        check("rst_ovf", 64'(dut8_ovf()), 64'(1'b0));

        // First operation issued straight after reset release: must be taken at the first edge.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, s, br, ov, lat);
            check($sformatf("vec%0d_sub", i), 64'(s), 64'(vecs[i].sub));
            check($sformatf("vec%0d_borrow", i), 64'(br), 64'(vecs[i].brw));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
`ifdef SUB_INT_SEQ_OVF_EN
            check($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].ovf));
`endif
            @(posedge clk); #1;
            check($sformatf("vec%0d_in_ready_after", i), 64'(u8_in_ready), 64'(1'b1));
            check($sformatf("vec%0d_out_valid_after", i), 64'(u8_out_valid), 64'(1'b0));
        end

        // Stall in DONE while inputs toggle, then consume with a new request pending.
        out_ready = 1'b0;
        A = 32'h0000_0010;
        B = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 999;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (u8_out_valid) begin
                lat = k;
                break;
            end
        end
        check("stall_latency", 64'(lat), 64'(4));
        for (int c = 0; c < 10; c++) begin
            A = $urandom;
            B = $urandom;
            in_valid = (c % 2 == 0);
            @(posedge clk); #1;
            check("stall_sub", 64'(u8_sub), 64'(32'h0000_000F));
            check("stall_borrow", 64'(u8_borrow), 64'(1'b0));
            check("stall_out_valid", 64'(u8_out_valid), 64'(1'b1));
            check("stall_in_ready", 64'(u8_in_ready), 64'(1'b0));
        end
        A = 32'd5;
        B = 32'd3;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("consume_out_valid", 64'(u8_out_valid), 64'(1'b0));
        check("consume_no_accept", 64'(u8_in_ready), 64'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 999;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (u8_out_valid) begin
                lat = k;
                break;
            end
        end
        check("reissue_latency", 64'(lat), 64'(4));
        check("reissue_sub", 64'(u8_sub), 64'(32'd2));
        @(posedge clk); #1;

        // Reset in the second BUSY cycle: aborted result must never surface.
        A = 32'hFFFF_0000;
        B = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(u8_in_ready), 64'(1'b1));
        check("abort_out_valid", 64'(u8_out_valid), 64'(1'b0));
        check("abort_sub", 64'(u8_sub), 64'(32'h0));
        check("abort_borrow", 64'(u8_borrow), 64'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("abort_no_result", 64'(u8_out_valid), 64'(1'b0));
        end
        run_op(32'd5, 32'd3, s, br, ov, lat);
        check("post_abort_sub", 64'(s), 64'(32'd2));
        check("post_abort_borrow", 64'(br), 64'(1'b0));
        check("post_abort_latency", 64'(lat), 64'(4));
        @(posedge clk); #1;

        // Random sweep over DIGIT = 1, 8, 32 running side by side.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] s1, s8, s32;
            logic         b1, b8, b32, o1, o8, o32, seen1, seen8, seen32;
            int           l1, l8, l32;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = a;
                1: a = '0;
                2: b = 32'hFFFF_FFFF;
                3: b = a + 32'd1;
                default: ;
            endcase
            exp_sub = a - b;
            exp_br  = (a < b);
            A = a;
            B = b;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            A = $urandom;
            B = $urandom;
            seen1 = 1'b0; seen8 = 1'b0; seen32 = 1'b0;
            l1 = 999; l8 = 999; l32 = 999;
            s1 = '0; s8 = '0; s32 = '0;
            b1 = 1'b0; b8 = 1'b0; b32 = 1'b0;
            o1 = 1'b0; o8 = 1'b0; o32 = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk); #1;
                if (!seen1 && u1_out_valid) begin
                    seen1 = 1'b1; l1 = k; s1 = u1_sub; b1 = u1_borrow;
`ifdef SUB_INT_SEQ_OVF_EN
                    o1 = u1_ovf;
`endif
                end
                if (!seen8 && u8_out_valid) begin
                    seen8 = 1'b1; l8 = k; s8 = u8_sub; b8 = u8_borrow; o8 = dut8_ovf();
                end
                if (!seen32 && u32_out_valid) begin
                    seen32 = 1'b1; l32 = k; s32 = u32_sub; b32 = u32_borrow;
`ifdef SUB_INT_SEQ_OVF_EN
                    o32 = u32_ovf;
`endif
                end
                if (seen1 && seen8 && seen32) break;
            end
            check($sformatf("rnd%0d_d1_sub", i), 64'(s1), 64'(exp_sub));
            check($sformatf("rnd%0d_d1_borrow", i), 64'(b1), 64'(exp_br));
            check($sformatf("rnd%0d_d1_latency", i), 64'(l1), 64'(32));
            check($sformatf("rnd%0d_d8_sub", i), 64'(s8), 64'(exp_sub));
            check($sformatf("rnd%0d_d8_borrow", i), 64'(b8), 64'(exp_br));
            check($sformatf("rnd%0d_d8_latency", i), 64'(l8), 64'(4));
            check($sformatf("rnd%0d_d32_sub", i), 64'(s32), 64'(exp_sub));
            check($sformatf("rnd%0d_d32_borrow", i), 64'(b32), 64'(exp_br));
            check($sformatf("rnd%0d_d32_latency", i), 64'(l32), 64'(1));
`ifdef SUB_INT_SEQ_OVF_EN
            check($sformatf("rnd%0d_d1_ovf", i), 64'(o1), 64'(model_ovf(a, b)));
            check($sformatf("rnd%0d_d8_ovf", i), 64'(o8), 64'(model_ovf(a, b)));
            check($sformatf("rnd%0d_d32_ovf", i), 64'(o32), 64'(model_ovf(a, b)));
`endif
            @(posedge clk); #1;
            check($sformatf("rnd%0d_all_idle", i),
                  64'({u1_in_ready, u8_in_ready, u32_in_ready}), 64'(3'b111));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
